complex_mult_pipe: RTL and testbench
====================================

COMPLEX_MULT_PIPE -- requirements
Module: complex_mult_pipe

Interface
REQ-001 Parameter data_in_width, default 8: signed width of each input component.
REQ-002 Parameter data_out_width, default 16: signed width of each output component.
REQ-003 Parameter shift, default 0: right-shift (scaling) applied to full-precision results; legal range 0..2*data_in_width.
REQ-004 Parameter saturate, default 1: 1 = clamp on overflow, 0 = wrap (truncate MSBs).
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  input operands valid this cycle.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 conj_b  input  1  when 1, operand b is conjugated (b_imag negated) before multiply; sampled with the operands.
REQ-010 a_real, a_imag, b_real, b_imag  input  data_in_width each  signed operands.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_real, out_imag  output  data_out_width each  signed result.
REQ-014 out_sat  output  1  set with a result if either component was clamped (saturate=1) or wrapped (saturate=0).

Function
REQ-015 Result SHALL be (a_real*b_real - a_imag*b_imag) + j(a_real*b_imag + a_imag*b_real), b_imag replaced by its negation when conj_b=1, computed at full precision (2*data_in_width+1 bits, negation of most-negative b_imag exact).
REQ-016 Scaling SHALL be round-half-up: add 2^(shift-1) when shift>0, then arithmetic right shift by shift.
REQ-017 Saturate=1: scaled value outside [-2^(data_out_width-1), 2^(data_out_width-1)-1] SHALL clamp to nearest bound; saturate=0: low data_out_width bits kept.
REQ-018 Pipeline SHALL be three register stages: S1 operand capture, S2 four products, S3 add/subtract, round, saturate; latency exactly 3 cycles from accepted input to out_valid with no stall.
REQ-019 A transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-020 Global advance enable SHALL be adv = out_ready || !out_valid; in_ready SHALL equal adv.
REQ-021 When adv=0 all stage registers and valid bits SHALL hold; outputs stable until accepted.
REQ-022 When adv=1 each stage valid bit SHALL take the previous stage valid (S1 takes in_valid); invalid slots travel as bubbles.
REQ-023 Sustained in_valid=1, out_ready=1 SHALL give one result per cycle, in input order.
REQ-024 Data registers of invalid stages are don't-care; out_real/out_imag/out_sat meaningful only when out_valid=1.

Reset
REQ-025 reset=1 at a clock edge SHALL clear all stage valid bits; out_valid=0, out_sat=0, out_real=0, out_imag=0 from the following cycle.
REQ-026 Reset mid-operation SHALL discard all in-flight results; in_ready=1 during and after reset.
REQ-027 Reset SHALL take priority over adv and over any simultaneous input transfer.

Structure
REQ-028 Shared package sdft_pkg SHALL hold the pipeline latency constant (3) and the rounding/saturation bound computation, shared with other sdft datapath blocks.
REQ-029 One sub-module complex_round_sat (round, shift, saturate one component, emits overflow flag), instantiated twice in S3.
REQ-030 No vendor primitives; multipliers inferred.

Verification (data_in_width=8, data_out_width=16 unless stated)
REQ-031 shift=0: a=3+4j, b=1+2j, conj_b=0 -> out -5+10j, out_sat=0, exactly 3 cycles later.
REQ-032 Same operands, conj_b=1 -> out 11-2j.
REQ-033 a=b=-128-128j, saturate=1 -> out_real=0, out_imag=32767, out_sat=1; saturate=0 -> out_imag=-32768, out_sat=1.
REQ-034 shift=3: a=100+0j, b=1+0j -> out_real=13; a=-100+0j -> out_real=-12; out_imag=0 both.
REQ-035 Stream 10 vectors, out_ready toggled pseudo-randomly -> all 10 results in order, none lost or duplicated, outputs stable while out_valid&&!out_ready.
REQ-036 Assert reset for one cycle with 3 results in flight -> no out_valid for those; next accepted input emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/sdft_pkg.sv
// Constants and rounding/saturation helpers shared by the sdft datapath blocks.
package sdft_pkg;

   localparam int pipe_latency = 3;

   // Half-LSB bias that makes a right shift by 'shift' round half-up.
   function automatic longint round_bias(input int shift);
      return (shift > 0) ? (longint'(1) <<< (shift - 1)) : longint'(0);
   endfunction

   function automatic longint sat_hi(input int width);
      return (longint'(1) <<< (width - 1)) - longint'(1);
   endfunction

   function automatic longint sat_lo(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

endpackage

// File: rtl/complex_mult_pipe_if.sv
// Operand/result handshake bundle for complex_mult_pipe; slave is the multiplier side.
interface complex_mult_pipe_if #(
   parameter int data_in_width  = 8,
   parameter int data_out_width = 16
);
   logic                             in_valid;
   logic                             in_ready;
   logic                             conj_b;
   logic signed [data_in_width-1:0]  a_real;
   logic signed [data_in_width-1:0]  a_imag;
   logic signed [data_in_width-1:0]  b_real;
   logic signed [data_in_width-1:0]  b_imag;
   logic                             out_valid;
   logic                             out_ready;
   logic signed [data_out_width-1:0] out_real;
   logic signed [data_out_width-1:0] out_imag;
   logic                             out_sat;

   modport master (
      output in_valid, conj_b, a_real, a_imag, b_real, b_imag, out_ready,
      input  in_ready, out_valid, out_real, out_imag, out_sat
   );

   modport slave (
      input  in_valid, conj_b, a_real, a_imag, b_real, b_imag, out_ready,
      output in_ready, out_valid, out_real, out_imag, out_sat
   );
endinterface

// File: rtl/complex_round_sat.sv
// Round-half-up, arithmetic shift and clamp/wrap of one signed component; combinational.
// ovf flags any scaled value outside the output range, whether it was clamped or wrapped.
module complex_round_sat
   import sdft_pkg::*;
#(
   parameter int in_width  = 18,
   parameter int out_width = 16,
   parameter int shift     = 0,
   parameter int saturate  = 1
) (
   input  logic signed [in_width-1:0]  value,
   output logic signed [out_width-1:0] result,
   output logic                        ovf
);
   // One guard bit above the wider of input and output keeps the bias add and bound compares exact.
   localparam int w = ((in_width > out_width) ? in_width : out_width) + 1;
   localparam logic signed [w-1:0] bias = w'(round_bias(shift));
   localparam logic signed [w-1:0] hi   = w'(sat_hi(out_width));
   localparam logic signed [w-1:0] lo   = w'(sat_lo(out_width));

   logic signed [w-1:0] ext;
   logic signed [w-1:0] biased;
   logic signed [w-1:0] scaled;

   assign ext    = w'(value);
   assign biased = ext + bias;
   assign scaled = biased >>> shift;

   always_comb begin
      ovf    = (scaled > hi) || (scaled < lo);
      result = out_width'(scaled);
      if ((saturate != 0) && ovf) begin
         result = (scaled > hi) ? out_width'(hi) : out_width'(lo);
      end
   end

endmodule

// File: rtl/complex_mult_pipe.sv
// Three-stage complex multiplier with optional conjugate of b, round-half-up scaling and clamp/wrap.
// Latency 3 cycles; a single advance enable stalls every stage while the output is held.
module complex_mult_pipe
   import sdft_pkg::*;
#(
   parameter int data_in_width  = 8,
   parameter int data_out_width = 16,
   parameter int shift          = 0,
   parameter int saturate       = 1
) (
   input logic                 clk,
   input logic                 reset,
   complex_mult_pipe_if.slave  bus
);
   // b_imag carries one extra bit so negating the most negative value stays exact.
   localparam int prod_width = 2 * data_in_width + 2;

   logic adv;

   logic                            s1_vld;
   logic signed [data_in_width-1:0] s1_ar;
   logic signed [data_in_width-1:0] s1_ai;
   logic signed [data_in_width-1:0] s1_br;
   logic signed [data_in_width:0]   s1_bi;

   logic                         s2_vld;
   logic signed [prod_width-1:0] s2_rr;
   logic signed [prod_width-1:0] s2_ii;
   logic signed [prod_width-1:0] s2_ri;
   logic signed [prod_width-1:0] s2_ir;

   logic signed [data_in_width:0]     bi_ext;
   logic signed [data_in_width:0]     bi_eff;
   logic signed [prod_width-1:0]      sum_re;
   logic signed [prod_width-1:0]      sum_im;
   logic signed [data_out_width-1:0]  res_re;
   logic signed [data_out_width-1:0]  res_im;
   logic                              ovf_re;
   logic                              ovf_im;

   assign adv          = bus.out_ready || !bus.out_valid;
   assign bus.in_ready = adv;

   assign bi_ext = (data_in_width + 1)'(bus.b_imag);
   assign bi_eff = bus.conj_b ? -bi_ext : bi_ext;

   assign sum_re = s2_rr - s2_ii;
   assign sum_im = s2_ri + s2_ir;

   complex_round_sat #(
      .in_width  (prod_width),
      .out_width (data_out_width),
      .shift     (shift),
      .saturate  (saturate)
   ) u_rs_re (
      .value  (sum_re),
      .result (res_re),
      .ovf    (ovf_re)
   );

   complex_round_sat #(
      .in_width  (prod_width),
      .out_width (data_out_width),
      .shift     (shift),
      .saturate  (saturate)
   ) u_rs_im (
      .value  (sum_im),
      .result (res_im),
      .ovf    (ovf_im)
   );

   // Valid chain and result registers; reset wins over advance and any input transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld        <= 1'b0;
         s2_vld        <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_real  <= '0;
         bus.out_imag  <= '0;
         bus.out_sat   <= 1'b0;
      end else if (adv) begin
         s1_vld        <= bus.in_valid;
         s2_vld        <= s1_vld;
         bus.out_valid <= s2_vld;
         if (s2_vld) begin
            bus.out_real <= res_re;
            bus.out_imag <= res_im;
            bus.out_sat  <= ovf_re || ovf_im;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_ar <= bus.a_real;
         s1_ai <= bus.a_imag;
         s1_br <= bus.b_real;
         s1_bi <= bi_eff;
         s2_rr <= prod_width'(s1_ar) * prod_width'(s1_br);
         s2_ii <= prod_width'(s1_ai) * prod_width'(s1_bi);
         s2_ri <= prod_width'(s1_ar) * prod_width'(s1_bi);
         s2_ir <= prod_width'(s1_ai) * prod_width'(s1_br);
      end
   end

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Bench for complex_mult_pipe: three instances (shift0/clamp, shift0/wrap, shift3/clamp) share one stimulus.
module tb_complex_mult_pipe;

   typedef struct {
      logic signed [7:0] ar;
      logic signed [7:0] ai;
      logic signed [7:0] br;
      logic signed [7:0] bi;
      logic              conj;
   } vec_t;

   typedef struct {
      int ar, ai, br, bi, conj;
      int e_re, e_im, e_sat, e1_im, e2_re;
   } dir_t;

   logic clk = 1'b0;
   logic reset;
   logic in_valid;
   logic conj_b;
   logic out_ready;
   logic signed [7:0] a_real, a_imag, b_real, b_imag;

   logic [2:0]        o_vld;
   logic [2:0]        o_rdy;
   logic [2:0]        o_sat;
   logic signed [15:0] o_re [3];
   logic signed [15:0] o_im [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      complex_mult_pipe_if #(.data_in_width(8), .data_out_width(16)) bus ();

      assign bus.in_valid  = in_valid;
      assign bus.conj_b    = conj_b;
      assign bus.a_real    = a_real;
      assign bus.a_imag    = a_imag;
      assign bus.b_real    = b_real;
      assign bus.b_imag    = b_imag;
      assign bus.out_ready = out_ready;
      assign o_vld[g]      = bus.out_valid;
      assign o_rdy[g]      = bus.in_ready;
      assign o_sat[g]      = bus.out_sat;
      assign o_re[g]       = bus.out_real;
      assign o_im[g]       = bus.out_imag;

      complex_mult_pipe #(
         .data_in_width  (8),
         .data_out_width (16),
         .shift          ((g == 2) ? 3 : 0),
         .saturate       ((g == 1) ? 0 : 1)
      ) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );
   end

   // Reference: exact integer product, round-half-up, then clamp (instances 0,2) or wrap (instance 1).
   function automatic void scale(input longint v, input int k,
                                 output logic signed [15:0] r, output logic ovf);
      int     sh = (k == 2) ? 3 : 0;
      longint s  = v;
      if (sh > 0) s = (v + (longint'(1) << (sh - 1))) >>> sh;
      ovf = (s > 32767) || (s < -32768);
      if (ovf && (k != 1)) r = (s > 0) ? 16'sh7fff : 16'sh8000;
      else                 r = 16'(s);
   endfunction

   function automatic void model(input vec_t v, input int k,
                                 output logic signed [15:0] er, output logic signed [15:0] ei,
                                 output logic es);
      longint bi = v.conj ? -longint'(v.bi) : longint'(v.bi);
      longint re = longint'(v.ar) * longint'(v.br) - longint'(v.ai) * bi;
      longint im = longint'(v.ar) * bi + longint'(v.ai) * longint'(v.br);
      logic o1, o2;
      scale(re, k, er, o1);
      scale(im, k, ei, o2);
      es = o1 | o2;
   endfunction

   function automatic logic signed [7:0] rnd8();
      int r = int'($urandom_range(0, 3));
      if (r == 0) return 8'sh80;
      if (r == 1) return 8'sh7f;
      return 8'($urandom);
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      v.ar   = rnd8();
      v.ai   = rnd8();
      v.br   = rnd8();
      v.bi   = rnd8();
      v.conj = 1'($urandom);
      return v;
   endfunction

   task automatic drive(input vec_t v);
      a_real = v.ar;
      a_imag = v.ai;
      b_real = v.br;
      b_imag = v.bi;
      conj_b = v.conj;
   endtask

   task automatic test_reset();
      vec_t v;
      int   n;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      v = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 1'b0};
      drive(v);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (o_vld[k] !== 1'b0 || o_sat[k] !== 1'b0 || o_rdy[k] !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctl dut%0d: vld=%b sat=%b rdy=%b, want 0 0 1", k, o_vld[k], o_sat[k], o_rdy[k]);
         end
         checks++;
         if (o_re[k] !== 16'sd0 || o_im[k] !== 16'sd0) begin
            errors++;
            $display("FAIL reset_data dut%0d: re=%0d im=%0d, want 0 0", k, o_re[k], o_im[k]);
         end
      end
      // Park a result at the output with out_ready low, then reset over it.
      @(posedge clk); #1;
      v = '{8'sd3, 8'sd4, 8'sd1, 8'sd2, 1'b0};
      drive(v);
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      n = 0;
      while (o_vld[0] !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
      checks++;
      if (o_vld[0] !== 1'b1 || o_rdy[0] !== 1'b0) begin
         errors++;
         $display("FAIL hold_stall: vld=%b rdy=%b, want 1 0", o_vld[0], o_rdy[0]);
      end
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (o_vld[k] !== 1'b0 || o_rdy[k] !== 1'b1 || o_re[k] !== 16'sd0 || o_im[k] !== 16'sd0 || o_sat[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_held dut%0d: vld=%b rdy=%b re=%0d im=%0d sat=%b, want 0 1 0 0 0",
                     k, o_vld[k], o_rdy[k], o_re[k], o_im[k], o_sat[k]);
         end
      end
      out_ready = 1'b1;
   endtask

   task automatic test_directed();
      dir_t tbl [5];
      vec_t v;
      int   lat;
      logic signed [15:0] er, ei;
      logic es;
      tbl = '{'{3, 4, 1, 2, 0,       -5,  10, 0,     10,  -1},
              '{3, 4, 1, 2, 1,       11,  -2, 0,     -2,   1},
              '{-128, -128, -128, -128, 0, 0, 32767, 1, -32768, 0},
              '{100, 0, 1, 0, 0,     100,  0, 0,      0,  13},
              '{-100, 0, 1, 0, 0,   -100,  0, 0,      0, -12}};
      for (int i = 0; i < 5; i++) begin
         v.ar = 8'(tbl[i].ar); v.ai = 8'(tbl[i].ai);
         v.br = 8'(tbl[i].br); v.bi = 8'(tbl[i].bi);
         v.conj = 1'(tbl[i].conj);
         drive(v);
         in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1 in_valid = 1'b0;
         lat = 1;
         while (o_vld[0] !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
         checks++;
         if (lat != 3) begin
            errors++;
            $display("FAIL latency vec%0d: %0d cycles, want 3", i, lat);
         end
         checks++;
         if (o_re[0] !== 16'(tbl[i].e_re) || o_im[0] !== 16'(tbl[i].e_im) || o_sat[0] !== 1'(tbl[i].e_sat)) begin
            errors++;
            $display("FAIL directed_clamp vec%0d: re=%0d im=%0d sat=%b, want %0d %0d %0d",
                     i, o_re[0], o_im[0], o_sat[0], tbl[i].e_re, tbl[i].e_im, tbl[i].e_sat);
         end
         checks++;
         if (o_im[1] !== 16'(tbl[i].e1_im) || o_sat[1] !== 1'(tbl[i].e_sat)) begin
            errors++;
            $display("FAIL directed_wrap vec%0d: im=%0d sat=%b, want %0d %0d",
                     i, o_im[1], o_sat[1], tbl[i].e1_im, tbl[i].e_sat);
         end
         checks++;
         if (o_re[2] !== 16'(tbl[i].e2_re)) begin
            errors++;
            $display("FAIL directed_shift vec%0d: re=%0d, want %0d", i, o_re[2], tbl[i].e2_re);
         end
         for (int k = 0; k < 3; k++) begin
            model(v, k, er, ei, es);
            checks++;
            if (o_re[k] !== er || o_im[k] !== ei || o_sat[k] !== es) begin
               errors++;
               $display("FAIL directed_model vec%0d dut%0d: re=%0d im=%0d sat=%b, want %0d %0d %b",
                        i, k, o_re[k], o_im[k], o_sat[k], er, ei, es);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      vec_t q[$];
      int   tag[$];
      vec_t v;
      int   cyc = 0, sent = 0, got = 0;
      logic signed [15:0] er, ei;
      logic es;
      out_ready = 1'b1;
      while (got < 20 && cyc < 100) begin
         if (sent < 20) begin v = rand_vec(); drive(v); in_valid = 1'b1; end
         else in_valid = 1'b0;
         #1;
         if (o_vld[0] === 1'b1) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL b2b_extra: output with nothing outstanding at cycle %0d", cyc);
            end else begin
               checks++;
               if (cyc - tag[0] != 3) begin
                  errors++;
                  $display("FAIL b2b_latency: result %0d after %0d cycles, want 3", got, cyc - tag[0]);
               end
               for (int k = 0; k < 3; k++) begin
                  model(q[0], k, er, ei, es);
                  checks++;
                  if (o_re[k] !== er || o_im[k] !== ei || o_sat[k] !== es) begin
                     errors++;
                     $display("FAIL b2b_data res%0d dut%0d: re=%0d im=%0d sat=%b, want %0d %0d %b",
                              got, k, o_re[k], o_im[k], o_sat[k], er, ei, es);
                  end
               end
               void'(q.pop_front());
               void'(tag.pop_front());
               got++;
            end
         end
         if (in_valid && o_rdy[0]) begin q.push_back(v); tag.push_back(cyc); sent++; end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got != 20) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, want 20", got);
      end
   endtask

   task automatic test_stream();
      vec_t q[$];
      vec_t v;
      int   cyc = 0, sent = 0, got = 0;
      logic hold = 1'b0;
      logic signed [15:0] p_re [3];
      logic signed [15:0] p_im [3];
      logic [2:0] p_sat = '0;
      logic signed [15:0] er, ei;
      logic es;
      while (got < 10 && cyc < 400) begin
         if (sent < 10 && ($urandom_range(0, 9) < 7)) begin v = rand_vec(); drive(v); in_valid = 1'b1; end
         else in_valid = 1'b0;
         out_ready = 1'($urandom);
         #1;
         checks++;
         if (o_rdy[0] !== (out_ready || !o_vld[0])) begin
            errors++;
            $display("FAIL stream_ready cycle %0d: in_ready=%b, want %b", cyc, o_rdy[0], out_ready || !o_vld[0]);
         end
         if (hold) begin
            for (int k = 0; k < 3; k++) begin
               checks++;
               if (o_vld[k] !== 1'b1 || o_re[k] !== p_re[k] || o_im[k] !== p_im[k] || o_sat[k] !== p_sat[k]) begin
                  errors++;
                  $display("FAIL stream_stable dut%0d cycle %0d: vld=%b re=%0d im=%0d, want 1 %0d %0d",
                           k, cyc, o_vld[k], o_re[k], o_im[k], p_re[k], p_im[k]);
               end
            end
         end
         if (o_vld[0] === 1'b1 && out_ready) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL stream_extra: output with nothing outstanding at cycle %0d", cyc);
            end else begin
               for (int k = 0; k < 3; k++) begin
                  model(q[0], k, er, ei, es);
                  checks++;
                  if (o_re[k] !== er || o_im[k] !== ei || o_sat[k] !== es) begin
                     errors++;
                     $display("FAIL stream_data res%0d dut%0d: re=%0d im=%0d sat=%b, want %0d %0d %b",
                              got, k, o_re[k], o_im[k], o_sat[k], er, ei, es);
                  end
               end
               void'(q.pop_front());
               got++;
            end
         end
         if (in_valid && o_rdy[0]) begin q.push_back(v); sent++; end
         hold = o_vld[0] && !out_ready;
         for (int k = 0; k < 3; k++) begin p_re[k] = o_re[k]; p_im[k] = o_im[k]; end
         p_sat = o_sat;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (got != 10 || q.size() != 0) begin
         errors++;
         $display("FAIL stream_count: got %0d results with %0d outstanding, want 10 and 0", got, q.size());
      end
      repeat (5) begin
         #1;
         checks++;
         if (o_vld !== 3'b000) begin
            errors++;
            $display("FAIL stream_dup: out_valid=%b after stream drained, want 000", o_vld);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_flight();
      vec_t v;
      int   lat;
      logic signed [15:0] er, ei;
      logic es;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         v = rand_vec(); drive(v); in_valid = 1'b1;
         if (i == 2) reset = 1'b1;
         #1;
         if (i == 2) begin
            checks++;
            if (o_rdy[0] !== 1'b1) begin
               errors++;
               $display("FAIL flight_ready_in_reset: in_ready=%b, want 1", o_rdy[0]);
            end
         end
         @(posedge clk); #1;
      end
      reset = 1'b0; in_valid = 1'b0;
      repeat (6) begin
         checks++;
         if (o_vld !== 3'b000 || o_rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL flight_flushed: out_valid=%b in_ready=%b, want 000 1", o_vld, o_rdy[0]);
         end
         @(posedge clk); #1;
      end
      v = rand_vec(); drive(v); in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 1;
      while (o_vld[0] !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL flight_latency: %0d cycles after reset, want 3", lat);
      end
      for (int k = 0; k < 3; k++) begin
         model(v, k, er, ei, es);
         checks++;
         if (o_re[k] !== er || o_im[k] !== ei || o_sat[k] !== es) begin
            errors++;
            $display("FAIL flight_data dut%0d: re=%0d im=%0d sat=%b, want %0d %0d %b",
                     k, o_re[k], o_im[k], o_sat[k], er, ei, es);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stream();
      test_reset_flight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
